// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and the
// memory geometry defaults it shares with the instruction memory read side.
package imem_loader_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DEPTH_BYTES_DEF = 512;
  localparam int CNT_W_DEF       = 8;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready stream of 32-bit instruction words feeding the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  word_t word_in;
  logic  word_valid;
  logic  word_last;
  logic  word_ready;

  modport master (output word_in, output word_valid, output word_last, input word_ready);
  modport slave  (input word_in, input word_valid, input word_last, output word_ready);

endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes instruction words from a stream and writes them into the
// byte-addressed instruction memory big-endian, holding the CPU until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      word_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        beat;
  word_t             word_q;
  logic              last_q;

  logic              handshake;
  logic [1:0]        beat_nx;
  logic [ADDR_W:0]   base_next_ext;
  logic              mem_full;
  logic [7:0]        lane_data;

  // Status outputs are pure state decodes; only the memory port is registered.
  assign word_if.word_ready = (state == ST_ACCEPT);
  assign busy               = (state == ST_ACCEPT) || (state == ST_WRITE);
  assign done               = (state == ST_DONE);
  assign overflow           = (state == ST_ERR);
  assign cpu_hold           = (state != ST_DONE);

  assign handshake     = word_if.word_valid & word_if.word_ready;
  assign beat_nx       = beat + 2'd1;
  // One extra bit so a base that lands exactly on DEPTH_BYTES is visible.
  assign base_next_ext = {1'b0, base} + (ADDR_W+1)'(4);
  assign mem_full      = (base_next_ext == DEPTH_EXT);

  // Byte lane for the next beat, MSB first.
  always_comb begin
    // NOTE: default assignment first, so a missing case arm cannot infer a latch.
    lane_data = word_q[31:24];
    case (beat_nx)
      2'd1:    lane_data = word_q[23:16];
      2'd2:    lane_data = word_q[15:8];
      2'd3:    lane_data = word_q[7:0];
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register
  // here is a control/datapath flop, so all of them take the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      base       <= '0;
      beat       <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_ACCEPT;
            base       <= '0;
            word_count <= '0;
          end
        end

        ST_ACCEPT: begin
          // start is deliberately not looked at here: a concurrent handshake wins.
          if (handshake) begin
            word_q   <= word_if.word_in;
            last_q   <= word_if.word_last;
            beat     <= 2'd0;
            mem_we   <= 1'b1;
            mem_addr <= base;
            mem_data <= word_if.word_in[31:24];
            state    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (beat != 2'd3) begin
            beat     <= beat_nx;
            mem_addr <= base + ADDR_W'(beat_nx);
            mem_data <= lane_data;
          end else begin
            mem_we     <= 1'b0;
            word_count <= word_count + CNT_W'(1);
            base       <= mem_full ? '0 : base_next_ext[ADDR_W-1:0];
            // A last word that exactly fills memory is still a clean finish.
            if (last_q)        state <= ST_DONE;
            else if (mem_full) state <= ST_ERR;
            else               state <= ST_ACCEPT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side counterpart to the instruction memory read port. It accepts 32-bit instruction words over a valid/ready stream and writes each one into the byte-addressed instruction memory as four big-endian byte writes. It holds the pipeline (NPC/PC/stage registers) in reset until the load completes, replacing file-based preload for synthesizable boot.

Parameters:
ADDR_W, 9, byte-address width of instruction memory
DEPTH_BYTES, 512, memory size in bytes; must be a multiple of 4
CNT_W, 8, word_count width; must hold DEPTH_BYTES/4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins load at byte address 0
word_in  in  32  instruction word, MSB = opcode byte
word_valid  in  1  word_in is valid
word_last  in  1  qualifies word_in as the final word of the image
word_ready  out  1  loader accepts word_in this cycle
mem_we  out  1  byte write strobe to instruction memory
mem_addr  out  ADDR_W  byte write address
mem_data  out  8  byte write data
cpu_hold  out  1  1 = keep pipeline in reset
busy  out  1  load in progress
done  out  1  image loaded; level, held until next start or reset
overflow  out  1  image exceeded DEPTH_BYTES; sticky until start or reset
word_count  out  CNT_W  number of words fully written

Behaviour:
- Reset (reset=0, async): state IDLE. word_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, busy=0, done=0, overflow=0, word_count=0.
- States: IDLE, ACCEPT, WRITE, DONE, ERR.
- IDLE: start=1 -> ACCEPT; clear addr, word_count, done, overflow.
- ACCEPT: word_ready=1, busy=1. A handshake is word_valid & word_ready. On handshake, latch word_in and word_last, set beat=0, go to WRITE. No handshake -> remain.
- WRITE: word_ready=0, busy=1. Four consecutive cycles with mem_we=1, at mem_addr = base+beat. mem_data is word[31:24], [23:16], [15:8], [7:0] for beats 0..3 (big-endian, MIPS order).
  - After beat 3: word_count += 1, base += 4.
  - Latched last=1 -> DONE.
  - Otherwise, base == DEPTH_BYTES (wrapped to 0) -> ERR.
  - Otherwise -> ACCEPT.
- Timing: handshake in cycle N; writes in N+1..N+4; word_ready high again at N+5. Throughput is one word per 5 cycles. mem_* outputs are registered.
- DONE: done=1, cpu_hold=0, busy=0. start=1 -> ACCEPT with clear, and cpu_hold=1 from the next cycle.
- ERR: overflow=1, cpu_hold=1, busy=0. Only start or reset exits; start behaves as in IDLE.
- A last word that exactly fills memory (base reaches DEPTH_BYTES together with last=1) -> DONE, not ERR.
- start while busy is ignored. start and a handshake in the same cycle: the handshake wins, start is ignored.
- word_valid dropping mid-WRITE has no effect; the word is already latched.
- Reset mid-WRITE aborts immediately. Partially written bytes remain in memory; mem_we=0 on reset assertion.
- cpu_hold is 1 in all states except DONE.

Decomposition:
- Shared package/header holds the state encoding constants (IDLE=0, ACCEPT=1, WRITE=2, DONE=3, ERR=4; 3 bits) and the DEPTH_BYTES/ADDR_W defaults shared with the instruction memory.
- No sub-module needed. The byte-lane select (beat -> byte slice) stays inline; a separate module would be a thin mux.

Test Plan:
- Reset low at t=0, release at t=3 -> all outputs at reset values; cpu_hold=1; word_ready=0 until start.
- start; one word 0x24010005 with last=1 -> writes at addrs 0,1,2,3 with data 0x24,0x01,0x00,0x05; done=1, cpu_hold=0, word_count=1 at cycle N+5.
- Three words, word_valid toggled low between them -> addresses 0..11 written in order; no writes while valid=0; word_count=3.
- 128 words, last on the 128th -> DONE, overflow=0. Repeat with 129 words -> ERR after word 128, overflow=1, word_ready=0, cpu_hold=1.
- Assert reset during beat 2 of word 0 -> mem_we drops asynchronously; state IDLE; start restarts at addr 0.
- start pulsed during WRITE -> ignored, sequence unaffected. start in DONE -> done=0, word_count=0, reload from addr 0.
